// File: rtl/cache_flush_sequencer.sv
// cache_flush_sequencer: flush-manager side of the cache flush handshake.
// Accepts one core flush request, flushes the DCache (writeback) and then the
// ICache (invalidate), then pulses flushComplete to the core and both caches.
// A per-phase watchdog forces completion and raises a sticky error flag.
// Optional macro RSD_CACHE_FLUSH_PARALLEL_EN issues both cache requests at once
// and waits for both completes in a single PAR_WAIT phase.
module cache_flush_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int PERF_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flushReq,
    output logic                      flushBusy,
    output logic                      icFlushReq,
    input  logic                      icFlushReqAck,
    input  logic                      icFlushComplete,
    output logic                      dcFlushReq,
    input  logic                      dcFlushReqAck,
    input  logic                      dcFlushComplete,
    output logic                      flushComplete,
    output logic                      flushTimeout,
    output logic [PERF_CNT_WIDTH-1:0] flushCount
);

    // Watchdog counter only needs to reach TIMEOUT_CYCLES; keep at least one bit.
    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    // The hit fires in the last allowed cycle so the request is visible for
    // exactly TIMEOUT_CYCLES cycles before DONE.
    localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

`ifdef RSD_CACHE_FLUSH_PARALLEL_EN
    typedef enum logic [1:0] {IDLE, PAR_WAIT, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, DC_REQ, DC_WAIT, IC_REQ, IC_WAIT, DONE} state_t;
`endif

    state_t                    r_state;
    state_t                    w_next;
    logic [WD_W-1:0]           r_wdog;
    logic                      r_timeout;
    logic [PERF_CNT_WIDTH-1:0] r_count;
    logic                      w_inPhase;
    logic                      w_wdogHit;
    logic                      w_phaseEntry;

`ifdef RSD_CACHE_FLUSH_PARALLEL_EN
    logic r_dcReq;
    logic r_icReq;
    logic r_dcDone;
    logic r_icDone;
    logic w_dcDoneNow;
    logic w_icDoneNow;

    assign w_inPhase    = (r_state == PAR_WAIT);
    assign w_phaseEntry = (r_state == IDLE) && (w_next == PAR_WAIT);
    // A complete arriving this cycle counts together with an earlier latched one.
    assign w_dcDoneNow  = r_dcDone | dcFlushComplete;
    assign w_icDoneNow  = r_icDone | icFlushComplete;
`else
    assign w_inPhase    = (r_state == DC_REQ) || (r_state == DC_WAIT) ||
                          (r_state == IC_REQ) || (r_state == IC_WAIT);
    assign w_phaseEntry = (w_next != r_state) &&
                          ((w_next == DC_REQ) || (w_next == IC_REQ));
`endif

    assign w_wdogHit = WD_EN && w_inPhase && (r_wdog == WD_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode; the watchdog takes priority over any handshake input.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (flushReq) begin
`ifdef RSD_CACHE_FLUSH_PARALLEL_EN
                w_next = PAR_WAIT;
`else
                w_next = DC_REQ;
`endif
            end
`ifdef RSD_CACHE_FLUSH_PARALLEL_EN
            PAR_WAIT: begin
                if (w_wdogHit || (w_dcDoneNow && w_icDoneNow)) w_next = DONE;
            end
`else
            DC_REQ: begin
                if (w_wdogHit)          w_next = DONE;
                else if (dcFlushReqAck) w_next = dcFlushComplete ? IC_REQ : DC_WAIT;
            end
            DC_WAIT: begin
                if (w_wdogHit)            w_next = DONE;
                else if (dcFlushComplete) w_next = IC_REQ;
            end
            IC_REQ: begin
                if (w_wdogHit)          w_next = DONE;
                else if (icFlushReqAck) w_next = icFlushComplete ? DONE : IC_WAIT;
            end
            IC_WAIT: begin
                if (w_wdogHit || icFlushComplete) w_next = DONE;
            end
`endif
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Moore output decode from state and registered flags only.
    always_comb begin
        flushBusy     = (r_state != IDLE);
        flushComplete = (r_state == DONE);
        flushTimeout  = r_timeout;
        flushCount    = r_count;
`ifdef RSD_CACHE_FLUSH_PARALLEL_EN
        dcFlushReq    = r_dcReq;
        icFlushReq    = r_icReq;
`else
        dcFlushReq    = (r_state == DC_REQ);
        icFlushReq    = (r_state == IC_REQ);
`endif
    end

    // Per-phase watchdog: restart on phase entry, count while waiting on a cache.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               r_wdog <= '0;
        else if (w_phaseEntry) r_wdog <= '0;
        else if (w_inPhase)    r_wdog <= r_wdog + WD_W'(1);
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_timeout <= 1'b0;
        else if (w_wdogHit) r_timeout <= 1'b1;
    end

    // Completed-flush counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_count <= '0;
        else if (r_state == DONE) r_count <= r_count + PERF_CNT_WIDTH'(1);
    end

`ifdef RSD_CACHE_FLUSH_PARALLEL_EN
    // Both requests rise on acceptance; each falls after its own ack or on phase exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dcReq <= 1'b0;
            r_icReq <= 1'b0;
        end else if (w_phaseEntry) begin
            r_dcReq <= 1'b1;
            r_icReq <= 1'b1;
        end else if (w_next != PAR_WAIT) begin
            r_dcReq <= 1'b0;
            r_icReq <= 1'b0;
        end else begin
            if (dcFlushReqAck) r_dcReq <= 1'b0;
            if (icFlushReqAck) r_icReq <= 1'b0;
        end
    end

    // Done flags latch each cache's complete during PAR_WAIT and clear in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dcDone <= 1'b0;
            r_icDone <= 1'b0;
        end else if (r_state == DONE) begin
            r_dcDone <= 1'b0;
            r_icDone <= 1'b0;
        end else if (w_inPhase) begin
            if (dcFlushComplete) r_dcDone <= 1'b1;
            if (icFlushComplete) r_icDone <= 1'b1;
        end
    end
`endif

endmodule
